// File: rtl/wptr_full_ctrl_pkg.sv
// Shared pointer helpers for the async FIFO write/read controllers.
// Functions work on a wide container; callers zero-extend and truncate to their pointer width.
package wptr_full_ctrl_pkg;

  localparam int unsigned PTR_MAX_W = 32;

  typedef logic [PTR_MAX_W-1:0] ptr_max_t;

  function automatic int unsigned ptr_width(input int unsigned addr_width);
    return addr_width + 1;
  endfunction

  function automatic ptr_max_t bin2gray(input ptr_max_t bin);
    return (bin >> 1) ^ bin;
  endfunction

  // Leading zeros from zero-extension leave the low bits of the result unchanged.
  function automatic ptr_max_t gray2bin(input ptr_max_t gray);
    ptr_max_t bin;
    bin = '0;
    bin[PTR_MAX_W-1] = gray[PTR_MAX_W-1];
    for (int i = PTR_MAX_W - 2; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
    return bin;
  endfunction

endpackage

// File: rtl/wptr_full_ctrl_gray2bin_conv.sv
// Combinational Gray-to-binary converter; each binary bit is the XOR of all Gray bits at or above it.
module gray2bin_conv
  import wptr_full_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = 5
) (
  input  logic [WIDTH-1:0] i_gray,
  output logic [WIDTH-1:0] o_bin
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign o_bin[i] = ^i_gray[WIDTH-1:i];
  end

endmodule

// File: rtl/wptr_full_ctrl.sv
// Write-domain pointer/flag controller of the async FIFO: binary and Gray write pointers,
// full, almost-full, conservative fill level and sticky overflow against the synced read pointer.
module wptr_full_ctrl
  import wptr_full_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned AF_THRESH  = 12
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_wr_en,
  input  logic [ADDR_WIDTH:0]   i_rptr_sync,
  input  logic                  i_ovf_clr,
  output logic [ADDR_WIDTH:0]   o_wptr,
  output logic [ADDR_WIDTH-1:0] o_waddr,
  output logic                  o_wr_fire,
  output logic                  o_full,
  output logic                  o_almost_full,
  output logic [ADDR_WIDTH:0]   o_level,
  output logic                  o_overflow
);

  localparam int unsigned PTR_W = ptr_width(ADDR_WIDTH);

  typedef logic [PTR_W-1:0] ptr_t;

  localparam ptr_t AF_LVL = ptr_t'(AF_THRESH);

  ptr_t wbin_q,  wbin_d;
  ptr_t wgray_q, wgray_d;
  logic full_q,  full_d;
  logic af_q,    af_d;
  ptr_t level_q, level_d;
  logic ovf_q,   ovf_d;

  ptr_t rbin;
  ptr_t rptr_full_pat;
  logic wr_fire;

  gray2bin_conv #(
    .WIDTH (PTR_W)
  ) u_rptr_g2b (
    .i_gray (i_rptr_sync),
    .o_bin  (rbin)
  );

  assign wr_fire = i_wr_en & ~full_q;

  // Full pattern: read pointer one lap behind, i.e. top two Gray bits inverted.
  assign rptr_full_pat = {~i_rptr_sync[PTR_W-1 -: 2], i_rptr_sync[PTR_W-3:0]};

  always_comb begin
    wbin_d  = wbin_q + ptr_t'(wr_fire);
    wgray_d = ptr_t'(bin2gray(ptr_max_t'(wbin_d)));
    full_d  = (wgray_d == rptr_full_pat);
    level_d = wbin_d - rbin;
    af_d    = (level_d >= AF_LVL);
    ovf_d   = (i_wr_en & full_q) | (ovf_q & ~i_ovf_clr);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wbin_q  <= '0;
      wgray_q <= '0;
      full_q  <= 1'b0;
      af_q    <= 1'b0;
      level_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      wbin_q  <= wbin_d;
      wgray_q <= wgray_d;
      full_q  <= full_d;
      af_q    <= af_d;
      level_q <= level_d;
      ovf_q   <= ovf_d;
    end
  end

  // The Gray pointer leaves straight from a flop so the synchronizer never sees glitches.
  assign o_wptr        = wgray_q;
  assign o_waddr       = wbin_q[ADDR_WIDTH-1:0];
  assign o_wr_fire     = wr_fire;
  assign o_full        = full_q;
  assign o_almost_full = af_q;
  assign o_level       = level_q;
  assign o_overflow    = ovf_q;

endmodule

// File: tb/tb_wptr_full_ctrl.sv
// Directed and randomized bench for wptr_full_ctrl with ADDR_WIDTH=2, AF_THRESH=3.
`timescale 1ns/1ps
module tb_wptr_full_ctrl;

  logic       clk = 1'b0;
  logic       rclk = 1'b0;
  logic       rst_n;
  logic       wr_en;
  logic       ovf_clr;
  logic [2:0] rptr_drv;
  logic [2:0] rptr_in;
  bit         use_sync;
  logic [2:0] wptr;
  logic [1:0] waddr;
  logic       fire;
  logic       full;
  logic       af;
  logic [2:0] level;
  logic       ovf;

  int checks = 0;
  int errors = 0;

  always #5   clk  = ~clk;
  always #6.5 rclk = ~rclk;

  wptr_full_ctrl #(
    .ADDR_WIDTH (2),
    .AF_THRESH  (3)
  ) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_wr_en       (wr_en),
    .i_rptr_sync   (rptr_in),
    .i_ovf_clr     (ovf_clr),
    .o_wptr        (wptr),
    .o_waddr       (waddr),
    .o_wr_fire     (fire),
    .o_full        (full),
    .o_almost_full (af),
    .o_level       (level),
    .o_overflow    (ovf)
  );

  function automatic logic [2:0] g(input logic [2:0] b);
    return (b >> 1) ^ b;
  endfunction

  // Consumer model on its own clock, with 2-flop synchronizers in both directions.
  logic [2:0] m_rbin, m_rgray, m_ws1, m_ws2, m_rs1, m_rs2;
  bit         rd_active;
  int         rd_cnt;

  always @(posedge rclk or negedge rst_n) begin
    if (!rst_n) begin
      m_rbin  <= '0;
      m_rgray <= '0;
      m_ws1   <= '0;
      m_ws2   <= '0;
      rd_cnt  <= 0;
    end else begin
      m_ws1 <= wptr;
      m_ws2 <= m_ws1;
      if (rd_active && ($urandom_range(0, 1) == 1) && (g(m_rbin) != m_ws2)) begin
        m_rbin  <= m_rbin + 3'd1;
        m_rgray <= g(m_rbin + 3'd1);
        rd_cnt  <= rd_cnt + 1;
      end
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_rs1 <= '0;
      m_rs2 <= '0;
    end else begin
      m_rs1 <= m_rgray;
      m_rs2 <= m_rs1;
    end
  end

  assign rptr_in = use_sync ? m_rs2 : rptr_drv;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    checks++;
    if ({wptr, waddr, full, af, level, ovf} !== 11'd0) begin
      errors++;
      $display("FAIL reset_state: got wptr=%b waddr=%b full=%b af=%b level=%0d ovf=%b, want all 0",
               wptr, waddr, full, af, level, ovf);
    end
    wr_en = 1'b1;
    tick();
    tick();
    checks++;
    if (wptr !== 3'b011) begin
      errors++;
      $display("FAIL reset_preburst_wptr: got %b want 011", wptr);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({wptr, waddr, full, af, level, ovf} !== 11'd0) begin
      errors++;
      $display("FAIL reset_async: got wptr=%b waddr=%b full=%b af=%b level=%0d ovf=%b, want all 0",
               wptr, waddr, full, af, level, ovf);
    end
    wr_en = 1'b0;
    #1;
    rst_n = 1'b1;
    tick();
    checks++;
    if (wptr !== 3'b000 || level !== 3'd0) begin
      errors++;
      $display("FAIL reset_release: got wptr=%b level=%0d want 000/0", wptr, level);
    end
  endtask

  task automatic test_fill();
    logic [2:0] exp_w[4];
    exp_w = '{3'b001, 3'b011, 3'b010, 3'b110};
    rptr_drv = 3'b000;
    wr_en = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      checks++;
      if (fire !== 1'b1) begin
        errors++;
        $display("FAIL fill_fire[%0d]: got %b want 1", k, fire);
      end
      tick();
      checks++;
      if (wptr !== exp_w[k]) begin
        errors++;
        $display("FAIL fill_wptr[%0d]: got %b want %b", k, wptr, exp_w[k]);
      end
      checks++;
      if (level !== 3'(k + 1) || waddr !== 2'(k + 1)) begin
        errors++;
        $display("FAIL fill_level[%0d]: got level=%0d waddr=%0d want %0d/%0d", k, level, waddr, k + 1, (k + 1) % 4);
      end
      checks++;
      if (af !== (k >= 2) || full !== (k == 3)) begin
        errors++;
        $display("FAIL fill_flags[%0d]: got af=%b full=%b want af=%b full=%b", k, af, full, k >= 2, k == 3);
      end
    end
  endtask

  task automatic test_overflow();
    wr_en = 1'b1;
    #1;
    checks++;
    if (fire !== 1'b0) begin
      errors++;
      $display("FAIL ovf_fire_blocked: got %b want 0", fire);
    end
    for (int k = 0; k < 2; k++) begin
      tick();
      checks++;
      if (wptr !== 3'b110 || ovf !== 1'b1 || full !== 1'b1) begin
        errors++;
        $display("FAIL ovf_hold[%0d]: got wptr=%b ovf=%b full=%b want 110/1/1", k, wptr, ovf, full);
      end
    end
    ovf_clr = 1'b1;
    tick();
    checks++;
    if (ovf !== 1'b1) begin
      errors++;
      $display("FAIL ovf_set_wins: got %b want 1", ovf);
    end
    wr_en = 1'b0;
    tick();
    checks++;
    if (ovf !== 1'b0) begin
      errors++;
      $display("FAIL ovf_clear: got %b want 0", ovf);
    end
    ovf_clr = 1'b0;
  endtask

  task automatic test_drain_wrap();
    logic [2:0] exp_w[4];
    exp_w = '{3'b111, 3'b101, 3'b100, 3'b000};
    rptr_drv = 3'b110;
    tick();
    checks++;
    if (full !== 1'b0 || level !== 3'd0 || af !== 1'b0) begin
      errors++;
      $display("FAIL drain: got full=%b level=%0d af=%b want 0/0/0", full, level, af);
    end
    wr_en = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++;
      if (wptr !== exp_w[k] || level !== 3'(k + 1)) begin
        errors++;
        $display("FAIL wrap_wptr[%0d]: got wptr=%b level=%0d want %b/%0d", k, wptr, level, exp_w[k], k + 1);
      end
    end
    checks++;
    if (full !== 1'b1) begin
      errors++;
      $display("FAIL wrap_full: got %b want 1", full);
    end
    wr_en = 1'b0;
  endtask

  task automatic test_concurrent();
    rptr_drv = 3'b111;
    tick();
    checks++;
    if (level !== 3'd3 || full !== 1'b0 || af !== 1'b1) begin
      errors++;
      $display("FAIL conc_setup: got level=%0d full=%b af=%b want 3/0/1", level, full, af);
    end
    wr_en = 1'b1;
    rptr_drv = 3'b101;
    tick();
    checks++;
    if (level !== 3'd3 || full !== 1'b0 || wptr !== 3'b001) begin
      errors++;
      $display("FAIL conc_same_cycle: got level=%0d full=%b wptr=%b want 3/0/001", level, full, wptr);
    end
    wr_en = 1'b0;
  endtask

  task automatic test_random();
    logic [2:0] prev;
    int         wr_cnt;
    int         occ;
    logic       f;
    wr_cnt = 0;
    wr_en = 1'b0;
    use_sync = 1'b1;
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    rd_active = 1'b1;
    tick();
    prev = wptr;
    repeat (400) begin
      wr_en = ($urandom_range(0, 1) == 1);
      #1;
      checks++;
      if (fire && full) begin
        errors++;
        $display("FAIL rand_write_while_full: got fire=%b full=%b", fire, full);
      end
      f = fire;
      tick();
      if (f) wr_cnt++;
      checks++;
      if ($countones(prev ^ wptr) > 1) begin
        errors++;
        $display("FAIL rand_gray_step: got %b -> %b, want <=1 bit change", prev, wptr);
      end
      checks++;
      if (level > 3'd4) begin
        errors++;
        $display("FAIL rand_level: got %0d want <=4", level);
      end
      occ = wr_cnt - rd_cnt;
      checks++;
      if (occ < 0 || occ > 4) begin
        errors++;
        $display("FAIL rand_occupancy: got %0d want 0..4", occ);
      end
      prev = wptr;
    end
    rd_active = 1'b0;
    wr_en = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    wr_en = 1'b0;
    ovf_clr = 1'b0;
    rptr_drv = 3'b000;
    use_sync = 1'b0;
    rd_active = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    test_reset();
    test_fill();
    test_overflow();
    test_drain_wrap();
    test_concurrent();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
